// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution result frame streamer.
package conv_pkg;

    localparam int DEF_IMAGE_WIDTH  = 256;
    localparam int DEF_IMAGE_HEIGHT = 256;

    typedef logic [7:0] pixel_t;

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_STREAM  = 1'b1
    } state_e;

    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/conv_frame_streamer_if.sv
// Write port from the convolution core and the outbound pixel stream.
interface conv_wr_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = 16
);
    pixel_t              wr_data;
    logic [ADDR_W-1:0]   wr_addr;
    logic                wr_en;
    logic                frame_done;

    modport master (output wr_data, wr_addr, wr_en, frame_done);
    modport slave  (input  wr_data, wr_addr, wr_en, frame_done);
endinterface

interface conv_axis_if
    import conv_pkg::*;
;
    pixel_t m_tdata;
    logic   m_tvalid;
    logic   m_tready;
    logic   m_tuser;
    logic   m_tlast;
    logic   m_eof;

    modport master (output m_tdata, m_tvalid, m_tuser, m_tlast, m_eof, input m_tready);
    modport slave  (input  m_tdata, m_tvalid, m_tuser, m_tlast, m_eof, output m_tready);
endinterface

// File: rtl/conv_skid_buffer.sv
// Two-entry valid/ready register slice: full throughput, registered outputs.
module conv_skid_buffer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          sk_vld_q, sk_vld_d;
    logic [DW-1:0] sk_data_q, sk_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            sk_vld_q   <= 1'b0;
            sk_data_q  <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            sk_vld_q   <= sk_vld_d;
            sk_data_q  <= sk_data_d;
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        sk_vld_d   = sk_vld_q;
        sk_data_d  = sk_data_q;
        s_ready    = !sk_vld_q;
        if (!out_vld_q || m_ready) begin
            // Output slot frees up: drain the skid entry first to keep order.
            if (sk_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = sk_data_q;
                sk_vld_d   = 1'b0;
            end else begin
                out_vld_d = s_valid;
                if (s_valid) out_data_d = s_data;
            end
        end else if (s_valid && !sk_vld_q) begin
            sk_vld_d  = 1'b1;
            sk_data_d = s_data;
        end
    end

    assign m_valid = out_vld_q;
    assign m_data  = out_data_q;

endmodule

// File: rtl/conv_frame_streamer.sv
// Captures one frame of addressed pixel writes, then replays it in raster order.
//   state      | meaning
//   ST_CAPTURE | accept writes into frame RAM, wait for full count or frame_done
//   ST_STREAM  | read RAM in raster order into the output slice, drop writes
module conv_frame_streamer
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
    input  logic        clk,
    input  logic        rst,
    conv_wr_if.slave    wr,
    conv_axis_if.master m,
    output logic        busy,
    output logic        overflow
);

    localparam int DEPTH  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int ADDR_W = addr_width(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int X_W    = addr_width(IMAGE_WIDTH);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(IMAGE_WIDTH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [X_W-1:0]    x_q, x_d;
    logic              issued_all_q, issued_all_d;
    logic              rd_vld_q, rd_vld_d;
    logic [2:0]        rd_mark_q, rd_mark_d;
    logic              overflow_q, overflow_d;

    pixel_t mem [DEPTH];
    pixel_t rd_data_q;

    logic in_range, accept, advance, rd_issue, eof_hs, s_ready;
    logic [10:0] skid_out;

    assign in_range = (CNT_W'(wr.wr_addr) < DEPTH_C);
    assign accept   = (state_q == ST_CAPTURE) && wr.wr_en && in_range;
    // The RAM output register is a pipeline stage: it only reloads when it can hand off.
    assign advance  = !rd_vld_q || s_ready;
    assign rd_issue = (state_q == ST_STREAM) && !issued_all_q && advance;
    assign eof_hs   = m.m_tvalid && m.m_tready && m.m_eof;

    always_ff @(posedge clk) begin
        if (accept) mem[wr.wr_addr] <= wr.wr_data;
        if (rd_issue) rd_data_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CAPTURE;
            wr_cnt_q     <= '0;
            rd_ptr_q     <= '0;
            x_q          <= '0;
            issued_all_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_mark_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            x_q          <= x_d;
            issued_all_q <= issued_all_d;
            rd_vld_q     <= rd_vld_d;
            rd_mark_q    <= rd_mark_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        x_d          = x_q;
        issued_all_d = issued_all_q;
        rd_vld_d     = rd_vld_q;
        rd_mark_d    = rd_mark_q;
        overflow_d   = overflow_q;
        case (state_q)
            ST_CAPTURE: begin
                if (accept) wr_cnt_d = wr_cnt_q + 1'b1;
                // An empty capture never streams; a same-cycle write counts as non-empty.
                if ((accept && (wr_cnt_q + 1'b1 == DEPTH_C)) ||
                    (wr.frame_done && (wr_cnt_q != '0 || accept)))
                    state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (wr.wr_en && in_range) overflow_d = 1'b1;
                if (advance) rd_vld_d = rd_issue;
                if (rd_issue) begin
                    rd_mark_d = {rd_ptr_q == LAST_PTR, x_q == LAST_X, rd_ptr_q == '0};
                    x_d       = (x_q == LAST_X) ? '0 : x_q + 1'b1;
                    if (rd_ptr_q == LAST_PTR) issued_all_d = 1'b1;
                    else                      rd_ptr_d     = rd_ptr_q + 1'b1;
                end
                if (eof_hs) begin
                    state_d      = ST_CAPTURE;
                    wr_cnt_d     = '0;
                    rd_ptr_d     = '0;
                    x_d          = '0;
                    issued_all_d = 1'b0;
                    rd_vld_d     = 1'b0;
                end
            end
            default: state_d = ST_CAPTURE;
        endcase
    end

    conv_skid_buffer #(.DW(11)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (rd_vld_q),
        .s_ready (s_ready),
        .s_data  ({rd_mark_q, rd_data_q}),
        .m_valid (m.m_tvalid),
        .m_ready (m.m_tready),
        .m_data  (skid_out)
    );

    assign m.m_eof   = skid_out[10];
    assign m.m_tlast = skid_out[9];
    assign m.m_tuser = skid_out[8];
    assign m.m_tdata = skid_out[7:0];
    assign busy      = (state_q == ST_STREAM);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Scoreboard bench for conv_frame_streamer on a 4x3 frame.
module tb_conv_frame_streamer;
    import conv_pkg::*;

    localparam int W      = 4;
    localparam int H      = 3;
    localparam int N      = W * H;
    localparam int ADDR_W = addr_width(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, overflow;

    conv_wr_if #(.ADDR_W(ADDR_W)) wrp ();
    conv_axis_if axis ();

    conv_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wrp.slave),
        .m        (axis.master),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
        logic       eof;
        logic       dchk;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   hs_cnt  = 0;
    bit   rnd_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] base, input logic [7:0] step, input int nchk);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = base + step * 8'(k);
            e.user = (k == 0);
            e.last = ((k % W) == W - 1);
            e.eof  = (k == N - 1);
            e.dchk = (k < nchk);
            sb.push_back(e);
        end
    endtask

    task automatic write_px(input int addr, input logic [7:0] data);
        wrp.wr_addr = ADDR_W'(addr);
        wrp.wr_data = data;
        wrp.wr_en   = 1'b1;
        @(posedge clk); #1;
        wrp.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, 32'(n < 500), 1);
    endtask

    // Downstream ready: constant high, or a coin flip each cycle.
    initial begin
        axis.m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            axis.m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on handshakes and polices stall stability.
    initial begin
        bit         prev_stall = 1'b0;
        bit         post_eof   = 1'b0;
        logic [10:0] prev_beat = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                post_eof   = 1'b0;
            end else begin
                if (post_eof) begin
                    chk("post_eof_valid", 32'(axis.m_tvalid), 0);
                    chk("post_eof_busy", 32'(busy), 0);
                    post_eof = 1'b0;
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(axis.m_tvalid), 1);
                    chk("stall_hold", 32'({axis.m_eof, axis.m_tlast, axis.m_tuser, axis.m_tdata}),
                        32'(prev_beat));
                end
                if (axis.m_tvalid && axis.m_tready) begin
                    hs_cnt++;
                    chk("beat_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        if (e.dchk) chk("data", 32'(axis.m_tdata), 32'(e.data));
                        chk("markers", 32'({axis.m_eof, axis.m_tlast, axis.m_tuser}),
                            32'({e.eof, e.last, e.user}));
                    end
                    if (axis.m_eof) post_eof = 1'b1;
                end
                prev_stall = axis.m_tvalid && !axis.m_tready;
                prev_beat  = {axis.m_eof, axis.m_tlast, axis.m_tuser, axis.m_tdata};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, n;
        wrp.wr_data    = '0;
        wrp.wr_addr    = '0;
        wrp.wr_en      = 1'b0;
        wrp.frame_done = 1'b0;
        #1;
        chk("rst_tvalid", 32'(axis.m_tvalid), 0);
        chk("rst_markers", 32'({axis.m_eof, axis.m_tlast, axis.m_tuser}), 0);
        chk("rst_tdata", 32'(axis.m_tdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full raster, ready held high; out-of-range and stream-time writes.
        write_px(N, 8'h99);
        chk("oor_overflow", 32'(overflow), 0);
        chk("oor_busy", 32'(busy), 0);
        push_frame(8'd10, 8'd1, N);
        for (int k = 0; k < N - 1; k++) write_px(k, 8'(10 + k));
        wrp.wr_addr = ADDR_W'(N - 1);
        wrp.wr_data = 8'(10 + N - 1);
        wrp.wr_en   = 1'b1;
        @(posedge clk); #1;
        chk("busy_rise", 32'(busy), 1);
        chk("tvalid_n", 32'(axis.m_tvalid), 0);
        wrp.wr_addr = ADDR_W'(2);
        wrp.wr_data = 8'hEE;
        @(posedge clk); #1;
        wrp.wr_en = 1'b0;
        chk("tvalid_n1", 32'(axis.m_tvalid), 0);
        chk("stream_overflow", 32'(overflow), 1);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            chk("no_bubble", 32'(axis.m_tvalid), 1);
            @(posedge clk); #1;
        end
        chk("end_tvalid", 32'(axis.m_tvalid), 0);
        chk("end_busy", 32'(busy), 0);

        // Same frame under random backpressure.
        rnd_mode = 1'b1;
        push_frame(8'd10, 8'd1, N);
        hs0 = hs_cnt;
        for (int k = 0; k < N; k++) write_px(k, 8'(10 + k));
        wait_idle("bp");
        chk("bp_handshakes", 32'(hs_cnt - hs0), N);
        chk("bp_overflow_sticky", 32'(overflow), 1);
        rnd_mode = 1'b0;

        // frame_done on an empty capture is ignored; then an early frame_done.
        wrp.frame_done = 1'b1;
        @(posedge clk); #1;
        wrp.frame_done = 1'b0;
        chk("empty_done_busy", 32'(busy), 0);
        for (int k = 0; k < 6; k++) write_px(k, 8'h55);
        chk("partial_busy", 32'(busy), 0);
        push_frame(8'h55, 8'd0, 6);
        hs0 = hs_cnt;
        wrp.frame_done = 1'b1;
        @(posedge clk); #1;
        wrp.frame_done = 1'b0;
        chk("early_busy", 32'(busy), 1);
        wait_idle("early");
        chk("early_handshakes", 32'(hs_cnt - hs0), N);

        // Reset after beat 5 handshake, then a fresh full frame.
        push_frame(8'h30, 8'd1, N);
        hs0 = hs_cnt;
        for (int k = 0; k < N; k++) write_px(k, 8'(8'h30 + k));
        n = 0;
        while (hs_cnt < hs0 + 6 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_reach", 32'(n < 100), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 32'(axis.m_tvalid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_overflow", 32'(overflow), 0);
        chk("mid_rst_markers", 32'({axis.m_eof, axis.m_tlast, axis.m_tuser}), 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_frame(8'hA0, 8'd1, N);
        hs0 = hs_cnt;
        for (int k = 0; k < N - 1; k++) write_px(k, 8'(8'hA0 + k));
        chk("fresh_needs_full", 32'(busy), 0);
        write_px(N - 1, 8'(8'hA0 + N - 1));
        wait_idle("fresh");
        chk("fresh_handshakes", 32'(hs_cnt - hs0), N);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
